// File: rtl/conv_pool_engine_if.sv
// Memory <-> compute handshake bundle: phase/status, DATA tile and FILTER in, conv/pool results out.
interface conv_pool_engine_if;
   logic [1:0]   state;
   logic [1:0]   MS;
   logic [127:0] DATA;
   logic [71:0]  FILTER;
   logic [1:0]   CS;
   logic [31:0]  ret22;
   logic [31:0]  ret33;

   modport master (output state, MS, DATA, FILTER, input CS, ret22, ret33);
   modport slave  (input state, MS, DATA, FILTER, output CS, ret22, ret33);
endinterface

// File: rtl/conv_pool_engine.sv
// 4x4 tile engine: 3x3 valid conv (one MAC per cycle) and 2x2/stride-2 max-pool, 2x2 outputs each.
module conv_pool_engine #(
   parameter bit OUT_SAT = 1'b1,
   parameter int ACC_W   = 20
) (
   input  logic clk,
   input  logic rst,
   conv_pool_engine_if.slave bus
);

   typedef enum logic [2:0] {IDLE, LOAD, CONV, POOL, DONE} fsm_t;

   fsm_t             fsm, fsm_nxt;
   logic [15:0][7:0] d_q;
   logic [8:0][7:0]  f_q;
   logic [ACC_W-1:0] acc, acc_nxt;
   logic [3:0]       t;
   logic [1:0]       o, p;
   logic [3:0][7:0]  conv_sh, pool_sh, pool_sh_nxt;
   logic [31:0]      ret22_q, ret33_q;
   logic             run, clr;

   assign run = (bus.state == 2'b10);
   assign clr = (bus.state == 2'b00);

   always_comb begin
      fsm_nxt = fsm;
      case (fsm)
         IDLE: if (run && bus.MS == 2'b10) fsm_nxt = LOAD;
         LOAD: fsm_nxt = run ? CONV : IDLE;
         CONV: if (!run) fsm_nxt = IDLE;
               else if (o == 2'd3 && t == 4'd8) fsm_nxt = POOL;
         POOL: if (!run) fsm_nxt = IDLE;
               else if (p == 2'd3) fsm_nxt = DONE;
         DONE: if (!run) fsm_nxt = IDLE;
         default: fsm_nxt = IDLE;
      endcase
   end

   // tap t -> filter (row, col); data window is offset by the output position o
   logic [1:0] tr, tc, dr, dc;
   logic [3:0] d_idx, f_idx;
   logic [15:0] prod;
   logic [7:0]  res_byte;

   always_comb begin
      tr = 2'd0;
      tc = 2'(t);
      if (t >= 4'd6) begin
         tr = 2'd2;
         tc = 2'(t - 4'd6);
      end else if (t >= 4'd3) begin
         tr = 2'd1;
         tc = 2'(t - 4'd3);
      end
   end

   assign dr       = 2'(o[1]) + tr;
   assign dc       = 2'(o[0]) + tc;
   assign d_idx    = {dr, dc};
   assign f_idx    = 4'(tr) * 4'd3 + 4'(tc);
   assign prod     = 16'(d_q[d_idx]) * 16'(f_q[f_idx]);
   assign acc_nxt  = acc + ACC_W'(prod);
   assign res_byte = (OUT_SAT && (|acc_nxt[ACC_W-1:8])) ? 8'hFF : acc_nxt[7:0];

   // pool window top-left byte is (2*p[1], 2*p[0])
   logic [3:0] pb;
   logic [7:0] m0, m1, pmax;

   assign pb   = {p[1], 1'b0, p[0], 1'b0};
   assign m0   = (d_q[pb]      > d_q[pb + 4'd1]) ? d_q[pb]      : d_q[pb + 4'd1];
   assign m1   = (d_q[pb + 4'd4] > d_q[pb + 4'd5]) ? d_q[pb + 4'd4] : d_q[pb + 4'd5];
   assign pmax = (m0 > m1) ? m0 : m1;

   always_comb begin
      pool_sh_nxt    = pool_sh;
      pool_sh_nxt[p] = pmax;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm     <= IDLE;
         d_q     <= '0;
         f_q     <= '0;
         acc     <= '0;
         t       <= '0;
         o       <= '0;
         p       <= '0;
         conv_sh <= '0;
         pool_sh <= '0;
         ret22_q <= '0;
         ret33_q <= '0;
      end else begin
         fsm <= fsm_nxt;
         case (fsm)
            LOAD: begin
               d_q <= bus.DATA;
               f_q <= bus.FILTER;
               acc <= '0;
               t   <= '0;
               o   <= '0;
               p   <= '0;
            end
            CONV: begin
               if (t == 4'd8) begin
                  conv_sh[o] <= res_byte;
                  acc        <= '0;
                  t          <= '0;
                  o          <= o + 2'd1;
               end else begin
                  acc <= acc_nxt;
                  t   <= t + 4'd1;
               end
            end
            POOL: begin
               pool_sh <= pool_sh_nxt;
               p       <= p + 2'd1;
            end
            default: ;
         endcase
         // last pool byte is bypassed so results publish on the same edge that enters DONE
         if (fsm == POOL && fsm_nxt == DONE) begin
            ret22_q <= conv_sh;
            ret33_q <= pool_sh_nxt;
         end else if (clr) begin
            ret22_q <= '0;
            ret33_q <= '0;
         end
      end
   end

   assign bus.CS    = (fsm == DONE) ? 2'b01 : 2'b00;
   assign bus.ret22 = ret22_q;
   assign bus.ret33 = ret33_q;

endmodule

// File: tb/tb_conv_pool_engine.sv
// Scoreboard bench for conv_pool_engine: saturating and wrapping instances driven in lockstep.
module tb_conv_pool_engine;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [1:0]   state  = 2'b00;
   logic [1:0]   ms     = 2'b00;
   logic [127:0] data   = '0;
   logic [71:0]  filter = '0;

   always #5 clk = ~clk;

   conv_pool_engine_if bus1 ();
   conv_pool_engine_if bus0 ();

   assign bus1.state = state;  assign bus0.state = state;
   assign bus1.MS = ms;        assign bus0.MS = ms;
   assign bus1.DATA = data;    assign bus0.DATA = data;
   assign bus1.FILTER = filter; assign bus0.FILTER = filter;

   conv_pool_engine #(.OUT_SAT(1'b1), .ACC_W(20)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   conv_pool_engine #(.OUT_SAT(1'b0), .ACC_W(20)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

   typedef struct {
      logic [31:0] r22s;
      logic [31:0] r22n;
      logic [31:0] r33;
   } exp_t;

   exp_t sb[$];
   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [127:0] NOM_D   = 128'h09000705_01040203_0A080608_02070101;
   localparam logic [71:0]  NOM_F   = 72'h04_05_00_04_00_05_00_02_03;
   localparam logic [31:0]  NOM_R22 = 32'h54666F67;
   localparam logic [31:0]  NOM_R33 = 32'h09070A08;

   function automatic logic [31:0] conv_model(input logic [127:0] d, input logic [71:0] f, input bit sat);
      logic [31:0] r;
      int s;
      r = '0;
      for (int oo = 0; oo < 4; oo++) begin
         s = 0;
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               s += int'(d[8*(4*(oo/2+i)+(oo%2)+j) +: 8]) * int'(f[8*(3*i+j) +: 8]);
         r[8*oo +: 8] = (sat && s > 255) ? 8'hFF : 8'(s);
      end
      return r;
   endfunction

   function automatic logic [31:0] pool_model(input logic [127:0] d);
      logic [31:0] r;
      logic [7:0] m, v;
      r = '0;
      for (int pp = 0; pp < 4; pp++) begin
         m = 8'd0;
         for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
               v = d[8*(4*(2*(pp/2)+i)+2*(pp%2)+j) +: 8];
               if (v > m) m = v;
            end
         r[8*pp +: 8] = m;
      end
      return r;
   endfunction

   // Starts a job from IDLE; lat = edges from the start edge to CS=01, 0 if it never came.
   task automatic run_job(input logic [127:0] d, input logic [71:0] f, input bit iso, output int lat);
      @(negedge clk);
      state = 2'b10; ms = 2'b10; data = d; filter = f;
      @(posedge clk);
      lat = 0;
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk); #1;
         if (iso && n == 1) data = '0;
         if (bus1.CS == 2'b01) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic leave_done();
      @(negedge clk);
      state = 2'b01; ms = 2'b00;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      int lat;
      exp_t e;
      rst = 1'b0; state = 2'b10; ms = 2'b10; data = NOM_D; filter = NOM_F;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (bus1.CS !== 2'b00) begin n_bad++; $display("FAIL rst_cs got=%b exp=00", bus1.CS); end
      n_cmp++; if (bus1.ret22 !== 32'h0) begin n_bad++; $display("FAIL rst_ret22 got=%h exp=0", bus1.ret22); end
      n_cmp++; if (bus1.ret33 !== 32'h0) begin n_bad++; $display("FAIL rst_ret33 got=%h exp=0", bus1.ret33); end
      n_cmp++; if (bus0.ret22 !== 32'h0) begin n_bad++; $display("FAIL rst_ret22_nosat got=%h exp=0", bus0.ret22); end
      sb.push_back('{NOM_R22, NOM_R22, NOM_R33});
      rst = 1'b1;
      lat = 0;
      for (int n = 0; n <= 60; n++) begin
         @(posedge clk); #1;
         if (bus1.CS == 2'b01) begin
            lat = n;
            break;
         end
      end
      e = sb.pop_front();
      n_cmp++; if (lat != 41) begin n_bad++; $display("FAIL rst_release_latency got=%0d exp=41", lat); end
      n_cmp++; if (bus1.ret22 !== e.r22s) begin n_bad++; $display("FAIL rst_run_ret22 got=%h exp=%h", bus1.ret22, e.r22s); end
      n_cmp++; if (bus1.ret33 !== e.r33) begin n_bad++; $display("FAIL rst_run_ret33 got=%h exp=%h", bus1.ret33, e.r33); end
      leave_done();
   endtask

   task automatic test_nominal();
      int lat;
      exp_t e;
      sb.push_back('{NOM_R22, NOM_R22, NOM_R33});
      run_job(NOM_D, NOM_F, 1'b0, lat);
      e = sb.pop_front();
      n_cmp++; if (lat != 41) begin n_bad++; $display("FAIL nom_latency got=%0d exp=41", lat); end
      n_cmp++; if (bus0.CS !== 2'b01) begin n_bad++; $display("FAIL nom_cs_nosat got=%b exp=01", bus0.CS); end
      n_cmp++; if (bus1.ret22 !== e.r22s) begin n_bad++; $display("FAIL nom_ret22 got=%h exp=%h", bus1.ret22, e.r22s); end
      n_cmp++; if (bus0.ret22 !== e.r22n) begin n_bad++; $display("FAIL nom_ret22_nosat got=%h exp=%h", bus0.ret22, e.r22n); end
      n_cmp++; if (bus1.ret33 !== e.r33) begin n_bad++; $display("FAIL nom_ret33 got=%h exp=%h", bus1.ret33, e.r33); end
      // memory acknowledges capture; DONE must hold regardless
      @(negedge clk); ms = 2'b11;
      repeat (3) @(posedge clk); #1;
      n_cmp++; if (bus1.CS !== 2'b01) begin n_bad++; $display("FAIL nom_ms11_cs got=%b exp=01", bus1.CS); end
      n_cmp++; if (bus1.ret22 !== NOM_R22) begin n_bad++; $display("FAIL nom_ms11_ret22 got=%h exp=%h", bus1.ret22, NOM_R22); end
      leave_done();
      n_cmp++; if (bus1.CS !== 2'b00) begin n_bad++; $display("FAIL nom_exit_cs got=%b exp=00", bus1.CS); end
      n_cmp++; if (bus1.ret33 !== NOM_R33) begin n_bad++; $display("FAIL nom_exit_ret33 got=%h exp=%h", bus1.ret33, NOM_R33); end
   endtask

   task automatic test_saturation();
      int lat;
      exp_t e;
      sb.push_back('{32'hFFFFFFFF, 32'h09090909, 32'hFFFFFFFF});
      run_job({128{1'b1}}, {72{1'b1}}, 1'b0, lat);
      e = sb.pop_front();
      n_cmp++; if (lat != 41) begin n_bad++; $display("FAIL sat_latency got=%0d exp=41", lat); end
      n_cmp++; if (bus1.ret22 !== e.r22s) begin n_bad++; $display("FAIL sat_ret22 got=%h exp=%h", bus1.ret22, e.r22s); end
      n_cmp++; if (bus0.ret22 !== e.r22n) begin n_bad++; $display("FAIL sat_ret22_nosat got=%h exp=%h", bus0.ret22, e.r22n); end
      n_cmp++; if (bus1.ret33 !== e.r33) begin n_bad++; $display("FAIL sat_ret33 got=%h exp=%h", bus1.ret33, e.r33); end
      n_cmp++; if (bus0.ret33 !== e.r33) begin n_bad++; $display("FAIL sat_ret33_nosat got=%h exp=%h", bus0.ret33, e.r33); end
      leave_done();
   endtask

   task automatic test_random();
      int lat;
      exp_t e;
      logic [127:0] d;
      logic [71:0] f;
      for (int k = 0; k < 4; k++) begin
         d = {$urandom, $urandom, $urandom, $urandom};
         f = {8'($urandom), $urandom, $urandom};
         sb.push_back('{conv_model(d, f, 1'b1), conv_model(d, f, 1'b0), pool_model(d)});
         run_job(d, f, 1'b0, lat);
         e = sb.pop_front();
         n_cmp++; if (lat != 41) begin n_bad++; $display("FAIL rnd%0d_latency got=%0d exp=41", k, lat); end
         n_cmp++; if (bus1.ret22 !== e.r22s) begin n_bad++; $display("FAIL rnd%0d_ret22 got=%h exp=%h", k, bus1.ret22, e.r22s); end
         n_cmp++; if (bus0.ret22 !== e.r22n) begin n_bad++; $display("FAIL rnd%0d_ret22_nosat got=%h exp=%h", k, bus0.ret22, e.r22n); end
         n_cmp++; if (bus1.ret33 !== e.r33) begin n_bad++; $display("FAIL rnd%0d_ret33 got=%h exp=%h", k, bus1.ret33, e.r33); end
         leave_done();
      end
   endtask

   task automatic test_isolation();
      int lat;
      exp_t e;
      sb.push_back('{NOM_R22, NOM_R22, NOM_R33});
      run_job(NOM_D, NOM_F, 1'b1, lat);
      e = sb.pop_front();
      n_cmp++; if (lat != 41) begin n_bad++; $display("FAIL iso_latency got=%0d exp=41", lat); end
      n_cmp++; if (bus1.ret22 !== e.r22s) begin n_bad++; $display("FAIL iso_ret22 got=%h exp=%h", bus1.ret22, e.r22s); end
      n_cmp++; if (bus1.ret33 !== e.r33) begin n_bad++; $display("FAIL iso_ret33 got=%h exp=%h", bus1.ret33, e.r33); end
      leave_done();
      data = NOM_D;
   endtask

   task automatic test_abort();
      bit seen_done;
      @(negedge clk);
      state = 2'b10; ms = 2'b10; data = {128{1'b1}}; filter = {72{1'b1}};
      @(posedge clk);          // start edge
      @(posedge clk);          // LOAD -> CONV
      repeat (20) @(posedge clk);
      #1 state = 2'b01;
      @(posedge clk); #1;
      n_cmp++; if (bus1.CS !== 2'b00) begin n_bad++; $display("FAIL abort_cs got=%b exp=00", bus1.CS); end
      n_cmp++; if (bus1.ret22 !== NOM_R22) begin n_bad++; $display("FAIL abort_ret22 got=%h exp=%h", bus1.ret22, NOM_R22); end
      n_cmp++; if (bus1.ret33 !== NOM_R33) begin n_bad++; $display("FAIL abort_ret33 got=%h exp=%h", bus1.ret33, NOM_R33); end
      seen_done = 1'b0;
      repeat (45) begin
         @(posedge clk); #1;
         if (bus1.CS == 2'b01) seen_done = 1'b1;
      end
      n_cmp++; if (seen_done) begin n_bad++; $display("FAIL abort_no_done got=done exp=idle"); end
      @(negedge clk); state = 2'b00;
      @(posedge clk); #1;
      n_cmp++; if (bus1.ret22 !== 32'h0) begin n_bad++; $display("FAIL clear_ret22 got=%h exp=0", bus1.ret22); end
      n_cmp++; if (bus1.ret33 !== 32'h0) begin n_bad++; $display("FAIL clear_ret33 got=%h exp=0", bus1.ret33); end
      n_cmp++; if (bus0.ret22 !== 32'h0) begin n_bad++; $display("FAIL clear_ret22_nosat got=%h exp=0", bus0.ret22); end
   endtask

   task automatic test_midrun_reset();
      int lat;
      exp_t e;
      run_job(NOM_D, NOM_F, 1'b0, lat);
      leave_done();
      @(negedge clk);
      state = 2'b10; ms = 2'b10;
      @(posedge clk);
      repeat (38) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      n_cmp++; if (bus1.CS !== 2'b00) begin n_bad++; $display("FAIL mrst_cs got=%b exp=00", bus1.CS); end
      n_cmp++; if (bus1.ret22 !== 32'h0) begin n_bad++; $display("FAIL mrst_ret22 got=%h exp=0", bus1.ret22); end
      n_cmp++; if (bus1.ret33 !== 32'h0) begin n_bad++; $display("FAIL mrst_ret33 got=%h exp=0", bus1.ret33); end
      state = 2'b01; ms = 2'b00;
      @(negedge clk); rst = 1'b1;
      sb.push_back('{NOM_R22, NOM_R22, NOM_R33});
      run_job(NOM_D, NOM_F, 1'b0, lat);
      e = sb.pop_front();
      n_cmp++; if (lat != 41) begin n_bad++; $display("FAIL mrst_rerun_latency got=%0d exp=41", lat); end
      n_cmp++; if (bus1.ret22 !== e.r22s) begin n_bad++; $display("FAIL mrst_rerun_ret22 got=%h exp=%h", bus1.ret22, e.r22s); end
      n_cmp++; if (bus1.ret33 !== e.r33) begin n_bad++; $display("FAIL mrst_rerun_ret33 got=%h exp=%h", bus1.ret33, e.r33); end
      leave_done();
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_saturation();
      test_random();
      test_isolation();
      test_abort();
      test_midrun_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
